// File: rtl/lcd_mode_sequencer_if.sv
// Register-side bus of the LCD mode sequencer: LCDC/LYC/STAT-enable inputs in,
// timing state, renderer strobe, interrupt pulses and CPU access grants out.
interface lcd_mode_sequencer_if;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [8:0] dot;
    logic       lyc_match;
    logic       drawline;
    logic       vblank_irq;
    logic       stat_irq;
    logic       cpu_vram_ok;
    logic       cpu_oam_ok;

    modport master (
        output lcd_enable, lyc, stat_ie,
        input  mode, ly, dot, lyc_match, drawline, vblank_irq, stat_irq,
               cpu_vram_ok, cpu_oam_ok
    );

    modport slave (
        input  lcd_enable, lyc, stat_ie,
        output mode, ly, dot, lyc_match, drawline, vblank_irq, stat_irq,
               cpu_vram_ok, cpu_oam_ok
    );
endinterface

// File: rtl/lcd_mode_sequencer.sv
// Dot-level LCD timing: mode 2/3/0/1 sequencing, drawline strobe, VBLANK/STAT pulses.
// Define ACCESS_LOCK_EN to gate CPU VRAM/OAM grants by mode; otherwise both stay 1.
module lcd_mode_sequencer #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    lcd_mode_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_e;

    typedef enum logic {ST_OFF, ST_RUN} state_e;

    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

    state_e     state_q;
    mode_e      mode_q, mode_d;
    logic [7:0] ly_q, ly_d;
    logic [8:0] dot_q, dot_d;
    logic       lyc_match_q, lyc_match_d;
    logic       drawline_q, drawline_d;
    logic       vblank_q, vblank_d;
    logic       stat_line_q, stat_line_d;
    logic       stat_irq_q;

    // Next position: a leaving-OFF edge lands on line 0 dot 0, otherwise advance one dot.
    always_comb begin
        dot_d = '0;
        ly_d  = '0;
        if (state_q == ST_RUN) begin
            if (dot_q == DOT_LAST) begin
                dot_d = '0;
                ly_d  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
                ly_d  = ly_q;
            end
        end
    end

    // Everything below is derived from the next position so outputs stay coherent.
    always_comb begin
        mode_d = MODE_HBLANK;
        if (ly_d >= LY_VIS)         mode_d = MODE_VBLANK;
        else if (dot_d < OAM_END)   mode_d = MODE_OAM;
        else if (dot_d < XFER_END)  mode_d = MODE_XFER;
        else                        mode_d = MODE_HBLANK;

        lyc_match_d = (ly_d == bus.lyc);
        drawline_d  = (ly_d < LY_VIS) && (dot_d == OAM_END);
        vblank_d    = (ly_d == LY_VIS) && (dot_d == 9'd0);
        stat_line_d = (bus.stat_ie[0] && mode_d == MODE_HBLANK) |
                      (bus.stat_ie[1] && mode_d == MODE_VBLANK) |
                      (bus.stat_ie[2] && mode_d == MODE_OAM)    |
                      (bus.stat_ie[3] && lyc_match_d);
    end

`ifdef ACCESS_LOCK_EN
    logic vram_ok_q, oam_ok_q;
    assign bus.cpu_vram_ok = vram_ok_q;
    assign bus.cpu_oam_ok  = oam_ok_q;
`else
    assign bus.cpu_vram_ok = 1'b1;
    assign bus.cpu_oam_ok  = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i || !bus.lcd_enable) begin
            state_q     <= ST_OFF;
            mode_q      <= MODE_HBLANK;
            ly_q        <= '0;
            dot_q       <= '0;
            lyc_match_q <= 1'b0;
            drawline_q  <= 1'b0;
            vblank_q    <= 1'b0;
            stat_line_q <= 1'b0;
            stat_irq_q  <= 1'b0;
`ifdef ACCESS_LOCK_EN
            vram_ok_q   <= 1'b1;
            oam_ok_q    <= 1'b1;
`endif
        end else begin
            state_q     <= ST_RUN;
            mode_q      <= mode_d;
            ly_q        <= ly_d;
            dot_q       <= dot_d;
            lyc_match_q <= lyc_match_d;
            drawline_q  <= drawline_d;
            vblank_q    <= vblank_d;
            stat_line_q <= stat_line_d;
            // A source taking over while the line is already high gives no pulse.
            stat_irq_q  <= stat_line_d & ~stat_line_q;
`ifdef ACCESS_LOCK_EN
            vram_ok_q   <= (mode_d != MODE_XFER);
            oam_ok_q    <= (mode_d != MODE_XFER) && (mode_d != MODE_OAM);
`endif
        end
    end

    assign bus.mode       = mode_q;
    assign bus.ly         = ly_q;
    assign bus.dot        = dot_q;
    assign bus.lyc_match  = lyc_match_q;
    assign bus.drawline   = drawline_q;
    assign bus.vblank_irq = vblank_q;
    assign bus.stat_irq   = stat_irq_q;
endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Bench for lcd_mode_sequencer: frame checkpoints via a scoreboard queue, a full-frame
// trace against closed-form timing, plus STAT blocking and disable/reset sequences.
module tb_lcd_mode_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_mode_sequencer_if bus ();
    lcd_mode_sequencer dut (.clk_i(clk), .reset_i(reset), .bus(bus.slave));

`ifdef ACCESS_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        int cyc;
        int mode;
        int ly;
        int dot;
        bit draw;
        bit vbl;
        bit vram;
        bit oam;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(int cyc, int mode, int ly, int dot, bit draw, bit vbl);
        vec_t v;
        v.cyc = cyc; v.mode = mode; v.ly = ly; v.dot = dot; v.draw = draw; v.vbl = vbl;
        v.vram = LOCK ? (mode != 3) : 1'b1;
        v.oam  = LOCK ? (mode < 2)  : 1'b1;
        return v;
    endfunction

    task automatic chk_off(input string tag);
        chk({tag, "_mode"}, bus.mode, 0);
        chk({tag, "_ly"}, bus.ly, 0);
        chk({tag, "_dot"}, bus.dot, 0);
        chk({tag, "_lyc_match"}, bus.lyc_match, 0);
        chk({tag, "_pulses"}, {bus.drawline, bus.vblank_irq, bus.stat_irq}, 0);
        chk({tag, "_grants"}, {bus.cpu_vram_ok, bus.cpu_oam_ok}, 3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.lcd_enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.lcd_enable = 1'b0;
        tick();
    endtask

    initial begin
        int errs, first_err, n_draw, n_vbl, n_stat, stat_at, n_lm;
        int p252, p456, n4;
        reset = 1'b1;
        bus.lcd_enable = 1'b1;
        bus.lyc = 8'd0;
        bus.stat_ie = 4'd0;
        tick();
        tick();
        chk_off("reset");

        tbl.push_back(mk(0,     2, 0,   0,   0, 0));
        tbl.push_back(mk(79,    2, 0,   79,  0, 0));
        tbl.push_back(mk(80,    3, 0,   80,  1, 0));
        tbl.push_back(mk(81,    3, 0,   81,  0, 0));
        tbl.push_back(mk(252,   0, 0,   252, 0, 0));
        tbl.push_back(mk(455,   0, 0,   455, 0, 0));
        tbl.push_back(mk(456,   2, 1,   0,   0, 0));
        tbl.push_back(mk(1468,  3, 3,   100, 0, 0));
        tbl.push_back(mk(1668,  0, 3,   300, 0, 0));
        tbl.push_back(mk(65663, 0, 143, 455, 0, 0));
        tbl.push_back(mk(65664, 1, 144, 0,   0, 1));
        tbl.push_back(mk(65665, 1, 144, 1,   0, 0));
        tbl.push_back(mk(70223, 1, 153, 455, 0, 0));
        tbl.push_back(mk(70224, 2, 0,   0,   0, 0));

        // Full frame with LYC=5 as the only STAT source.
        do_reset();
        bus.lyc = 8'd5;
        bus.stat_ie = 4'b1000;
        bus.lcd_enable = 1'b1;
        foreach (tbl[i]) sb.push_back(tbl[i]);
        errs = 0; first_err = -1; n_draw = 0; n_vbl = 0; n_stat = 0; stat_at = -1; n_lm = 0;
        for (int c = 0; c <= 70224; c++) begin
            int ely, edot, emode;
            bit edraw, evbl, elm, estat, evram, eoam;
            tick();
            ely   = (c / 456) % 154;
            edot  = c % 456;
            emode = (ely >= 144) ? 1 : (edot < 80) ? 2 : (edot < 252) ? 3 : 0;
            edraw = (ely < 144) && (edot == 80);
            evbl  = (ely == 144) && (edot == 0);
            elm   = (ely == 5);
            estat = (c == 2280);
            evram = LOCK ? (emode != 3) : 1'b1;
            eoam  = LOCK ? (emode < 2)  : 1'b1;
            if (bus.ly != 8'(ely) || bus.dot != 9'(edot) || bus.mode != 2'(emode) ||
                bus.drawline != edraw || bus.vblank_irq != evbl || bus.lyc_match != elm ||
                bus.stat_irq != estat || bus.cpu_vram_ok != evram || bus.cpu_oam_ok != eoam) begin
                if (first_err < 0) first_err = c;
                errs++;
            end
            if (c < 70224) begin
                n_draw += int'(bus.drawline);
                n_vbl  += int'(bus.vblank_irq);
                n_lm   += int'(bus.lyc_match);
                if (bus.stat_irq) begin n_stat++; stat_at = c; end
            end
            if (sb.size() > 0 && sb[0].cyc == c) begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("c%0d_mode", c), bus.mode, e.mode);
                chk($sformatf("c%0d_ly", c), bus.ly, e.ly);
                chk($sformatf("c%0d_dot", c), bus.dot, e.dot);
                chk($sformatf("c%0d_draw_vbl", c), {bus.drawline, bus.vblank_irq}, {e.draw, e.vbl});
                chk($sformatf("c%0d_grants", c), {bus.cpu_vram_ok, bus.cpu_oam_ok}, {e.vram, e.oam});
            end
        end
        chk("frame_trace_errs", errs, 0);
        if (errs != 0) $display("  first trace divergence at cycle %0d", first_err);
        chk("scoreboard_drained", sb.size(), 0);
        chk("drawline_per_frame", n_draw, 144);
        chk("vblank_per_frame", n_vbl, 1);
        chk("stat_per_frame", n_stat, 1);
        chk("stat_cycle", stat_at, 2280);
        chk("lyc_match_cycles", n_lm, 456);

        // HBLANK + OAM sources: the line stays high across the HBLANK->OAM boundary.
        do_reset();
        bus.lyc = 8'd200;
        bus.stat_ie = 4'd0;
        bus.lcd_enable = 1'b1;
        p252 = 0; p456 = 0; n4 = 0;
        for (int c = 0; c <= 700; c++) begin
            tick();
            if (c == 252) p252 = int'(bus.stat_irq);
            if (c == 456) p456 = int'(bus.stat_irq);
            n4 += int'(bus.stat_irq);
            if (c == 100) bus.stat_ie = 4'b0101;
        end
        chk("blk_pulse_dot252", p252, 1);
        chk("blk_no_pulse_line1", p456, 0);
        chk("blk_pulse_count", n4, 1);

        // Disable mid-frame, re-enable, then reset mid-line.
        do_reset();
        bus.lyc = 8'd0;
        bus.stat_ie = 4'd0;
        bus.lcd_enable = 1'b1;
        for (int c = 0; c <= 3292; c++) tick();
        chk("pre_disable_pos", {bus.ly, 7'd0, bus.dot}, {8'd7, 7'd0, 9'd100});
        bus.stat_ie = 4'hF;
        bus.lcd_enable = 1'b0;
        tick();
        chk_off("disable");
        tick();
        tick();
        chk("off_hold_dot", bus.dot, 0);
        bus.stat_ie = 4'd0;
        bus.lcd_enable = 1'b1;
        tick();
        chk("reenable_mode", bus.mode, 2);
        chk("reenable_pos", {bus.ly, 7'd0, bus.dot}, 0);
        for (int c = 1; c <= 200; c++) tick();
        chk("pre_reset_dot", bus.dot, 200);
        reset = 1'b1;
        tick();
        chk_off("midline_reset");
        reset = 1'b0;
        tick();
        chk("post_reset_mode", bus.mode, 2);
        chk("post_reset_pos", {bus.ly, 7'd0, bus.dot}, 0);
        tick();
        chk("post_reset_dot1", bus.dot, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
